fpa_arbiter: RTL and testbench

FPA_ARBITER -- requirements
Module: fpa_arbiter

---
 rtl/fpa_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_fpa_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fpa_arbiter.sv
// Two-requester front end sharing one combinational IEEE-754 single-precision adder.
// Define FPA_ARB_STATS_EN to build the per-requester completion counters cnt0/cnt1.

module fpa (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // Round-to-nearest-even on the G/R/S bits; an exponent of 255 or more overflows to infinity.
  function automatic logic [31:0] round_pack(input logic s, input logic [8:0] e, input logic [26:0] m);
    logic        up;
    logic [24:0] mr;
    logic [8:0]  ex;
    up = m[2] & (m[1] | m[0] | m[3]);
    mr = {1'b0, m[26:3]} + {24'd0, up};
    ex = e;
    if (mr[24]) begin
      mr = mr >> 1;
      ex = ex + 9'd1;
    end
    if (ex >= 9'd255) round_pack = {s, 8'hFF, 23'd0};
    else              round_pack = {s, mr[23] ? ex[7:0] : 8'd0, mr[22:0]};
  endfunction

  logic        a_nan, b_nan, a_inf, b_inf, swap, sub, sticky;
  logic [31:0] big, sml;
  logic [7:0]  big_e, sml_e, diff;
  logic [26:0] big_m, sml_m, sml_sh, norm;
  logic [27:0] raw;
  logic [8:0]  exp_n;
  logic [4:0]  lz, shamt;

  always_comb begin
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    swap  = b[30:0] > a[30:0];
    big   = swap ? b : a;
    sml   = swap ? a : b;
    // Denormals use exponent 1 with no hidden bit.
    big_e = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    sml_e = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    big_m = {|big[30:23], big[22:0], 3'b000};
    sml_m = {|sml[30:23], sml[22:0], 3'b000};
    diff  = big_e - sml_e;
    if (diff >= 8'd27) begin
      sml_sh = 27'd0;
      sticky = |sml_m;
    end else begin
      sml_sh = sml_m >> diff;
      sticky = |(sml_m & ((27'd1 << diff) - 27'd1));
    end
    sml_sh[0] = sml_sh[0] | sticky;
    sub   = big[31] ^ sml[31];
    raw   = sub ? ({1'b0, big_m} - {1'b0, sml_sh}) : ({1'b0, big_m} + {1'b0, sml_sh});
    exp_n = {1'b0, big_e};
    lz    = lzc27(raw[26:0]);
    shamt = 5'd0;
    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_n = exp_n + 9'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results fall into the denormal range.
      shamt = (9'(lz) < exp_n) ? lz : 5'(exp_n - 9'd1);
      norm  = raw[26:0] << shamt;
      exp_n = exp_n - 9'(shamt);
    end

    if (a_nan || b_nan)                      sum = QNAN;
    else if (a_inf && b_inf && (a[31] != b[31])) sum = QNAN;
    else if (a_inf)                          sum = a;
    else if (b_inf)                          sum = b;
    else if (raw == 28'd0)                   sum = {big[31] & sml[31], 31'd0};
    else                                     sum = round_pack(big[31], exp_n, norm);
  end
endmodule

module fpa_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        busy,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t      state, state_nxt;
  logic [31:0] op_a, op_b, sum;
  logic        tag, last_grant;
  logic        grant0, grant1, accept, done;

  fpa u_fpa (
    .a  (op_a),
    .b  (op_b),
    .sum(sum)
  );

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          // On contention the requester that did not win last time is served.
          grant0    = req0_valid && (!req1_valid || last_grant);
          grant1    = req1_valid && !grant0;
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: state_nxt = OUT;
      OUT: begin
        if (!rst && res_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == OUT) && !rst;
  assign busy       = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage boundary: operand capture on accept, then adder result capture in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      tag        <= 1'b0;
      last_grant <= 1'b1;
      res_data   <= '0;
      res_id     <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= grant1 ? req1_a : req0_a;
        op_b       <= grant1 ? req1_b : req0_b;
        tag        <= grant1;
        last_grant <= grant1;
      end
      if (state == CALC) begin
        res_data <= sum;
        res_id   <= tag;
      end
    end
  end

`ifdef FPA_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (done) begin
      if (!res_id && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (res_id && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif
endmodule

// File: tb/tb_fpa_arbiter.sv
// Directed self-checking bench for fpa_arbiter: handshakes, arbitration, back-pressure,
// special values, reset abort and the optional completion counters.
module tb_fpa_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, res_valid, res_id, busy;
  logic [31:0] res_data;
  logic [15:0] cnt0, cnt1;

  int checks = 0;
  int passed = 0;
  int exp_c0 = 0;
  int exp_c1 = 0;

  always #5 clk = ~clk;

  fpa_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  function automatic logic [15:0] cnt_model(input int n);
`ifdef FPA_ARB_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  // Stimulus only: one uncontended operation completing with res_ready held high.
  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    res_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    if (id) exp_c1++; else exp_c0++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready: got %b want 0", req0_ready); else passed++;
    checks++; if (req1_ready !== 1'b0) $display("FAIL reset_req1_ready: got %b want 0", req1_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
    checks++; if (res_data !== 32'h0) $display("FAIL reset_res_data: got %h want 00000000", res_data); else passed++;
    checks++; if (res_id !== 1'b0) $display("FAIL reset_res_id: got %b want 0", res_id); else passed++;
    checks++; if (cnt0 !== 16'h0) $display("FAIL reset_cnt0: got %h want 0000", cnt0); else passed++;
    checks++; if (cnt1 !== 16'h0) $display("FAIL reset_cnt1: got %h want 0000", cnt1); else passed++;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    exp_c0 = 0; exp_c1 = 0;
  endtask

  task automatic test_single_req0();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; res_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL single_grant: got %b want 1", req0_ready); else passed++;
    checks++; if (req1_ready !== 1'b0) $display("FAIL single_other_ready: got %b want 0", req1_ready); else passed++;
    @(negedge clk);
    // Operand change after accept must not reach the in-flight result.
    req0_valid = 1'b0; req0_a = 32'h7F80_0000; req0_b = 32'hC000_0000;
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy_calc: got %b want 1", busy); else passed++;
    checks++; if (res_valid !== 1'b0) $display("FAIL single_valid_n1: got %b want 0", res_valid); else passed++;
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b1) $display("FAIL single_valid_n2: got %b want 1", res_valid); else passed++;
    checks++; if (res_data !== 32'h4040_0000) $display("FAIL single_data: got %h want 40400000", res_data); else passed++;
    checks++; if (res_id !== 1'b0) $display("FAIL single_id: got %b want 0", res_id); else passed++;
    exp_c0++;
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b0) $display("FAIL single_valid_after: got %b want 0", res_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_contention();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_c0 = 0; exp_c1 = 0;
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
    req1_valid = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
    res_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL cont_first_req0: got %b want 1", req0_ready); else passed++;
    checks++; if (req1_ready !== 1'b0) $display("FAIL cont_first_req1: got %b want 0", req1_ready); else passed++;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b0) $display("FAIL cont_calc_req1: got %b want 0", req1_ready); else passed++;
    @(negedge clk); #1;
    checks++; if (res_data !== 32'h4080_0000) $display("FAIL cont_res0_data: got %h want 40800000", res_data); else passed++;
    checks++; if (res_id !== 1'b0) $display("FAIL cont_res0_id: got %b want 0", res_id); else passed++;
    checks++; if (req1_ready !== 1'b0) $display("FAIL cont_out_req1: got %b want 0", req1_ready); else passed++;
    exp_c0++;
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) $display("FAIL cont_second_req1: got %b want 1", req1_ready); else passed++;
    checks++; if (req0_ready !== 1'b0) $display("FAIL cont_second_req0: got %b want 0", req0_ready); else passed++;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (res_data !== 32'h4000_0000) $display("FAIL cont_res1_data: got %h want 40000000", res_data); else passed++;
    checks++; if (res_id !== 1'b1) $display("FAIL cont_res1_id: got %b want 1", res_id); else passed++;
    exp_c1++;
    @(negedge clk); #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL cont_third_req0: got %b want 1", req0_ready); else passed++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (res_data !== 32'h4080_0000) $display("FAIL cont_res2_data: got %h want 40800000", res_data); else passed++;
    exp_c0++;
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; res_ready = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL bp_grant: got %b want 1", req0_ready); else passed++;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'h3FC0_0000; req1_b = 32'h3F00_0000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (res_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, res_valid); else passed++;
      checks++; if (res_data !== 32'h4040_0000) $display("FAIL bp_hold_data[%0d]: got %h want 40400000", i, res_data); else passed++;
      checks++; if (res_id !== 1'b0) $display("FAIL bp_hold_id[%0d]: got %b want 0", i, res_id); else passed++;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_hold_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready}); else passed++;
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b1) $display("FAIL bp_handoff_valid: got %b want 1", res_valid); else passed++;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_handoff_ready: got %b want 00", {req0_ready, req1_ready}); else passed++;
    exp_c0++;
    @(negedge clk); #1;
    checks++; if (req1_ready !== 1'b1) $display("FAIL bp_next_req1: got %b want 1", req1_ready); else passed++;
    checks++; if (req0_ready !== 1'b0) $display("FAIL bp_next_req0: got %b want 0", req0_ready); else passed++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (res_data !== 32'h4000_0000) $display("FAIL bp_res1_data: got %h want 40000000", res_data); else passed++;
    checks++; if (res_id !== 1'b1) $display("FAIL bp_res1_id: got %b want 1", res_id); else passed++;
    exp_c1++;
  endtask

  task automatic test_special_values();
    logic [31:0] va [3] = '{32'h7F80_0000, 32'h3F80_0000, 32'h0000_0001};
    logic [31:0] vb [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0001};
    logic [31:0] vr [3] = '{32'h7F80_0000, 32'h0000_0000, 32'h0000_0002};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_a = va[i]; req1_b = vb[i]; res_ready = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b1) $display("FAIL special_grant[%0d]: got %b want 1", i, req1_ready); else passed++;
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (res_data !== vr[i]) $display("FAIL special_data[%0d]: got %h want %h", i, res_data, vr[i]); else passed++;
      checks++; if (res_id !== 1'b1) $display("FAIL special_id[%0d]: got %b want 1", i, res_id); else passed++;
      exp_c1++;
    end
  endtask

  task automatic test_reset_in_calc();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; res_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL abort_grant: got %b want 1", req0_ready); else passed++;
    @(negedge clk);
    req0_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy_in_rst: got %b want 0", busy); else passed++;
    @(negedge clk);
    rst = 1'b0; exp_c0 = 0; exp_c1 = 0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", busy); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (res_valid !== 1'b0) $display("FAIL abort_no_result[%0d]: got %b want 0", i, res_valid); else passed++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_counters();
    run_op(1'b0, 32'h3F80_0000, 32'h3F80_0000);
    run_op(1'b1, 32'h4000_0000, 32'h3F80_0000);
    run_op(1'b0, 32'h4040_0000, 32'h3F80_0000);
    run_op(1'b1, 32'h3F00_0000, 32'h3F00_0000);
    run_op(1'b0, 32'h4080_0000, 32'hC000_0000);
    @(negedge clk); #1;
    checks++; if (cnt0 !== cnt_model(exp_c0)) $display("FAIL cnt0: got %0d want %0d", cnt0, cnt_model(exp_c0)); else passed++;
    checks++; if (cnt1 !== cnt_model(exp_c1)) $display("FAIL cnt1: got %0d want %0d", cnt1, cnt_model(exp_c1)); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_contention();
    test_back_pressure();
    test_special_values();
    test_reset_in_calc();
    test_counters();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
